// File: rtl/spi_apb_pkg.sv
// Shared widths, FSM state type and SPI register map for the APB requester.
package spi_apb_pkg;

  localparam int unsigned APB_ADDR_W = 3;
  localparam int unsigned APB_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  localparam logic [APB_ADDR_W-1:0] SPI_CR1 = 3'b000;
  localparam logic [APB_ADDR_W-1:0] SPI_CR2 = 3'b001;
  localparam logic [APB_ADDR_W-1:0] SPI_BR  = 3'b010;

endpackage

// File: rtl/spi_apb_master_bridge_if.sv
// Command/response stream plus APB requester signals; master = bridge side.
interface spi_apb_master_bridge_if
  import spi_apb_pkg::*;
#(
  parameter int unsigned ADDR_W = APB_ADDR_W,
  parameter int unsigned DATA_W = APB_DATA_W
) ();

  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic              cmd_write_i;
  logic [ADDR_W-1:0] cmd_addr_i;
  logic [DATA_W-1:0] cmd_wdata_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [DATA_W-1:0] rsp_rdata_o;
  logic              rsp_err_o;
  logic              rsp_timeout_o;
  logic              PSEL_o;
  logic              PENABLE_o;
  logic              PWRITE_o;
  logic [ADDR_W-1:0] PADDR_o;
  logic [DATA_W-1:0] PWDATA_o;
  logic [DATA_W-1:0] PRDATA_i;
  logic              PREADY_i;
  logic              PSLVERR_i;

  modport master (
    input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, rsp_ready_i,
           PRDATA_i, PREADY_i, PSLVERR_i,
    output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
           PSEL_o, PENABLE_o, PWRITE_o, PADDR_o, PWDATA_o
  );

  modport slave (
    output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, rsp_ready_i,
           PRDATA_i, PREADY_i, PSLVERR_i,
    input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
           PSEL_o, PENABLE_o, PWRITE_o, PADDR_o, PWDATA_o
  );

endinterface

// File: rtl/spi_apb_master_bridge_wait_timer.sv
// ACCESS wait-state counter: cleared by load, counts while enabled, saturates at TIMEOUT-1.
module apb_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic PCLK,
  input  logic PRESET,
  input  logic load,
  input  logic en,
  output logic tc_c
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_q;

  assign tc_c = (cnt_q == CNT_W'(TIMEOUT - 1));

  // Holds at terminal count so the counter can never wrap.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (en && !tc_c) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_apb_master_bridge.sv
// APB3 requester: one outstanding command -> SETUP/ACCESS transfer -> held response,
// with a wait-state timeout guarding against a slave that never raises PREADY.
module spi_apb_master_bridge
  import spi_apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = APB_ADDR_W,
  parameter int unsigned DATA_W  = APB_DATA_W,
  parameter int unsigned TIMEOUT = 16
) (
  input logic                     PCLK,
  input logic                     PRESET,
  spi_apb_master_bridge_if.master bus
);

  apb_state_e state_q, state_d;

  logic              cmd_fire_c;
  logic              xfer_done_c;
  logic              timeout_c;
  logic              tmr_tc_c;

  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;
  logic              rsp_timeout_q;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // PREADY is checked before the terminal count so a late PREADY beats the timeout.
  always_comb begin
    state_d     = state_q;
    cmd_fire_c  = 1'b0;
    xfer_done_c = 1'b0;
    timeout_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid_i) begin
          cmd_fire_c = 1'b1;
          state_d    = ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (bus.PREADY_i) begin
          xfer_done_c = 1'b1;
          state_d     = ST_RESP;
        end else if (tmr_tc_c) begin
          timeout_c = 1'b1;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .load   (state_q == ST_SETUP),
    .en     ((state_q == ST_ACCESS) && !bus.PREADY_i),
    .tc_c   (tmr_tc_c)
  );

  // Request fields live from capture until the next capture; response fields until next completion.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      if (cmd_fire_c) begin
        pwrite_q <= bus.cmd_write_i;
        paddr_q  <= bus.cmd_addr_i;
        pwdata_q <= bus.cmd_wdata_i;
      end
      if (xfer_done_c) begin
        rsp_err_q     <= bus.PSLVERR_i;
        rsp_timeout_q <= 1'b0;
        rsp_rdata_q   <= pwrite_q ? '0 : bus.PRDATA_i;
      end else if (timeout_c) begin
        rsp_err_q     <= 1'b1;
        rsp_timeout_q <= 1'b1;
        rsp_rdata_q   <= '0;
      end
    end
  end

  assign bus.cmd_ready_o   = (state_q == ST_IDLE) && !PRESET;
  assign bus.PSEL_o        = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign bus.PENABLE_o     = (state_q == ST_ACCESS);
  assign bus.PWRITE_o      = pwrite_q;
  assign bus.PADDR_o       = paddr_q;
  assign bus.PWDATA_o      = pwdata_q;
  assign bus.rsp_valid_o   = (state_q == ST_RESP);
  assign bus.rsp_rdata_o   = rsp_rdata_q;
  assign bus.rsp_err_o     = rsp_err_q;
  assign bus.rsp_timeout_o = rsp_timeout_q;

endmodule
